// File: rtl/alu_arbiter_pkg.sv
// Shared opcodes, FSM states and opcode legality check for the ALU arbiter.
package alu_arbiter_pkg;

  localparam logic [5:0] OP_NOP = 6'h00;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_SLT = 6'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU: ADD/SUB with carry/borrow, logic ops, unsigned SLT.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        z,
  output logic        cout,
  output logic        err
);

  logic [32:0] wide;

  // Result, flags and legality decode; unsupported ops yield S=0.
  always_comb begin
    wide = '0;
    s    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        s    = wide[31:0];
        cout = wide[32];
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        s    = wide[31:0];
        cout = wide[32];
      end
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_XOR:  s = a ^ b;
      OP_SLT:  s = {31'd0, (a < b)};
      default: s = '0;
    endcase
    z   = (s == '0);
    err = !is_legal_op(op);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU: arbitrate, register operands,
// execute, and hold the registered result until the consumer takes it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic [5:0]    r0_op,
  input  logic [DW-1:0] r0_a,
  input  logic [DW-1:0] r0_b,
  input  logic          r0_cin,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic [5:0]    r1_op,
  input  logic [DW-1:0] r1_a,
  input  logic [DW-1:0] r1_b,
  input  logic          r1_cin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_s,
  output logic          rsp_z,
  output logic          rsp_cout,
  output logic          rsp_err
);

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          grant_id;
  logic          accept;
  logic [5:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          cin_q;
  logic          id_q;
  logic [31:0]   alu_s;
  logic          alu_z;
  logic          alu_cout;
  logic          alu_err;

  // Winner among valid requesters; ties go to the one not granted last (or r0).
  always_comb begin
    grant_id = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = (RR_EN != 0) ? ~last_grant : 1'b0;
    end else if (r1_valid) begin
      grant_id = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and ready; ready is gated by reset so it reads 0 while held.
  always_comb begin
    state_next = state;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (r0_valid || r1_valid)) begin
          r0_ready   = ~grant_id;
          r1_ready   = grant_id;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture; op reg is cleared every non-accept cycle so it is
  // only non-zero during EXEC and each issue presents a fresh opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      id_q       <= 1'b0;
    end else if (accept) begin
      last_grant <= grant_id;
      op_q       <= grant_id ? r1_op  : r0_op;
      a_q        <= grant_id ? r1_a   : r0_a;
      b_q        <= grant_id ? r1_b   : r0_b;
      cin_q      <= grant_id ? r1_cin : r0_cin;
      id_q       <= grant_id;
    end else begin
      op_q       <= OP_NOP;
    end
  end

  alu u_alu (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .cin  (cin_q),
    .s    (alu_s),
    .z    (alu_z),
    .cout (alu_cout),
    .err  (alu_err)
  );

  // Response registers: load in EXEC, hold through RESP until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_s     <= '0;
      rsp_z     <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_q;
      rsp_s     <= alu_s;
      rsp_z     <= alu_z;
      rsp_cout  <= alu_cout;
      rsp_err   <= alu_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_valid = 1'b0, r1_valid = 1'b0, rsp_ready = 1'b0;
  logic [5:0]  r0_op = '0, r1_op = '0;
  logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic        r0_cin = 1'b0, r1_cin = 1'b0;

  logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_err;
  logic [31:0] rsp_s;
  logic        fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_z, fp_rsp_cout, fp_rsp_err;
  logic [31:0] fp_rsp_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_EN(1), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .rsp_z(rsp_z), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  // Fixed-priority instance sharing the same stimulus.
  alu_arbiter #(.RR_EN(0), .DW(32)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(fp_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_cin(r0_cin),
    .r1_valid(r1_valid), .r1_ready(fp_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_cin(r1_cin),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_s(fp_rsp_s),
    .rsp_z(fp_rsp_z), .rsp_cout(fp_rsp_cout), .rsp_err(fp_rsp_err)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        z;
    logic        cout;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        z;
    logic        cout;
    logic        err;
    logic        id;
  } rsp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU from the arithmetic definitions.
  function automatic rsp_t ref_alu(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
    rsp_t        r;
    logic [63:0] wide;
    r.s = '0; r.cout = 1'b0; r.err = 1'b0; r.id = 1'b0;
    case (op)
      6'h20: begin wide = 64'(a) + 64'(b) + 64'(cin); r.s = wide[31:0]; r.cout = (wide > 64'hFFFF_FFFF); end
      6'h22: begin r.s = a - b; r.cout = (a < b); end
      6'h24: r.s = a & b;
      6'h25: r.s = a | b;
      6'h26: r.s = a ^ b;
      6'h2A: r.s = (a < b) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.z = (r.s == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
    return $urandom;
  endfunction

  task automatic do_reset();
    r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one op on r0 from IDLE and check latency and result fields.
  task automatic run_vec(input vec_t v, input int idx);
    r0_valid = 1'b1; r0_op = v.op; r0_a = v.a; r0_b = v.b; r0_cin = v.cin;
    rsp_ready = 1'b1;
    #1 chk($sformatf("vec%0d.ready", idx), r0_ready, 1);
    @(negedge clk);
    r0_valid = 1'b0;
    #1 chk($sformatf("vec%0d.exec_valid", idx), rsp_valid, 0);
    @(negedge clk);
    #1;
    chk($sformatf("vec%0d.valid", idx), rsp_valid, 1);
    chk($sformatf("vec%0d.s", idx), rsp_s, v.s);
    chk($sformatf("vec%0d.z", idx), rsp_z, v.z);
    chk($sformatf("vec%0d.cout", idx), rsp_cout, v.cout);
    chk($sformatf("vec%0d.err", idx), rsp_err, v.err);
    chk($sformatf("vec%0d.id", idx), rsp_id, 0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[13];
    logic [5:0]  ops[9];
    rsp_t        m_pend, m_exp, w;
    logic        m_free, m_lg, m_rsp_valid, e0, e1;
    int          m_cnt;

    vecs[0]  = '{6'h20, 32'd5,          32'd7,          1'b1, 32'd13,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{6'h22, 32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{6'h22, 32'd3,          32'd3,          1'b0, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[3]  = '{6'h3F, 32'd9,          32'd4,          1'b1, 32'd0,          1'b1, 1'b0, 1'b1};
    vecs[4]  = '{6'h20, 32'd1,          32'd1,          1'b0, 32'd2,          1'b0, 1'b0, 1'b0};
    vecs[5]  = '{6'h20, 32'd1,          32'd1,          1'b1, 32'd3,          1'b0, 1'b0, 1'b0};
    vecs[6]  = '{6'h24, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 32'h0000_F000,  1'b0, 1'b0, 1'b0};
    vecs[7]  = '{6'h25, 32'h0000_00F0,  32'h0000_000F,  1'b0, 32'h0000_00FF,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{6'h26, 32'hFFFF_0000,  32'hFF00_FF00,  1'b0, 32'h00FF_FF00,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{6'h2A, 32'd1,          32'hFFFF_FFFF,  1'b0, 32'd1,          1'b0, 1'b0, 1'b0};
    vecs[10] = '{6'h2A, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[11] = '{6'h20, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1, 1'b1, 1'b0};
    vecs[12] = '{6'h22, 32'd5,          32'd3,          1'b1, 32'd2,          1'b0, 1'b0, 1'b0};

    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h3F, 6'h00, 6'h21};

    // Reset state.
    do_reset();
    #1;
    chk("reset.r0_ready", r0_ready, 0);
    chk("reset.r1_ready", r1_ready, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_s", rsp_s, 0);
    chk("reset.rsp_id", rsp_id, 0);
    chk("reset.flags", {rsp_z, rsp_cout, rsp_err}, 0);
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Consumer stall: response held, no grants, then IDLE on acceptance.
    r0_valid = 1'b1; r0_op = 6'h20; r0_a = 32'd10; r0_b = 32'd20; r0_cin = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    r0_valid = 1'b0;
    @(negedge clk);
    r0_valid = 1'b1; r1_valid = 1'b1;
    r1_op = 6'h26; r1_a = 32'hF0; r1_b = 32'h0F; r1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d.valid", i), rsp_valid, 1);
      chk($sformatf("stall%0d.s", i), rsp_s, 32'd30);
      chk($sformatf("stall%0d.id", i), rsp_id, 0);
      chk($sformatf("stall%0d.flags", i), {rsp_z, rsp_cout, rsp_err}, 0);
      chk($sformatf("stall%0d.readys", i), {r0_ready, r1_ready}, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall.release_valid", rsp_valid, 0);
    chk("stall.idle_r1_ready", r1_ready, 1);
    chk("stall.idle_r0_ready", r0_ready, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);

    // Ties after reset: round-robin alternates, fixed priority always r0.
    do_reset();
    r0_valid = 1'b1; r0_op = 6'h20; r0_a = 32'd1; r0_b = 32'd1; r0_cin = 1'b0;
    r1_valid = 1'b1; r1_op = 6'h26; r1_a = 32'hF0; r1_b = 32'h0F; r1_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d.valid", k), rsp_valid, 1);
      chk($sformatf("tie%0d.id", k), rsp_id, k % 2);
      chk($sformatf("tie%0d.s", k), rsp_s, (k % 2 == 1) ? 32'hFF : 32'd2);
      chk($sformatf("tie%0d.fp_valid", k), fp_rsp_valid, 1);
      chk($sformatf("tie%0d.fp_id", k), fp_rsp_id, 0);
      chk($sformatf("tie%0d.fp_s", k), fp_rsp_s, 32'd2);
      if (k < 3) repeat (3) @(negedge clk);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted during EXEC discards the operation.
    r0_valid = 1'b1; r0_op = 6'h20; r0_a = 32'd5; r0_b = 32'd7; r0_cin = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_exec.readys", {r0_ready, r1_ready, fp_r0_ready, fp_r1_ready}, 0);
    chk("rst_exec.valid", {rsp_valid, fp_rsp_valid}, 0);
    chk("rst_exec.s", rsp_s | fp_rsp_s, 0);
    chk("rst_exec.misc", {rsp_id, rsp_z, rsp_cout, rsp_err, fp_rsp_id, fp_rsp_z, fp_rsp_cout, fp_rsp_err}, 0);
    r0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_exec.no_stale%0d", i), rsp_valid, 0);
    end
    @(negedge clk);

    // Randomized traffic against a transaction model (free/countdown/pending).
    m_free = 1'b1; m_lg = 1'b1; m_rsp_valid = 1'b0; m_cnt = 0;
    m_pend = '{default: '0}; m_exp = '{default: '0};
    for (int cyc = 0; cyc < 600; cyc++) begin
      r0_valid = ($urandom_range(0, 99) < 55);
      r1_valid = ($urandom_range(0, 99) < 55);
      r0_op = ops[$urandom_range(0, 8)]; r0_a = rnd_opnd(); r0_b = rnd_opnd(); r0_cin = 1'($urandom_range(0, 1));
      r1_op = ops[$urandom_range(0, 8)]; r1_a = rnd_opnd(); r1_b = rnd_opnd(); r1_cin = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 99) < 65);
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (m_free) begin
        if (r0_valid && r1_valid) begin
          if (m_lg) e0 = 1'b1; else e1 = 1'b1;
        end else if (r0_valid) e0 = 1'b1;
        else if (r1_valid) e1 = 1'b1;
      end
      chk("rnd.r0_ready", r0_ready, e0);
      chk("rnd.r1_ready", r1_ready, e1);
      chk("rnd.rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
        chk("rnd.rsp_id", rsp_id, m_exp.id);
        chk("rnd.rsp_s", rsp_s, m_exp.s);
        chk("rnd.rsp_flags", {rsp_z, rsp_cout, rsp_err}, {m_exp.z, m_exp.cout, m_exp.err});
      end
      if (m_rsp_valid && rsp_ready) begin
        m_rsp_valid = 1'b0;
        m_free = 1'b1;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_rsp_valid = 1'b1;
          m_exp = m_pend;
        end
      end
      if (e0 || e1) begin
        m_free = 1'b0;
        m_cnt = 1;
        m_lg = e1;
        w = e1 ? ref_alu(r1_op, r1_a, r1_b, r1_cin) : ref_alu(r0_op, r0_a, r0_b, r0_cin);
        w.id = e1;
        m_pend = w;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
